// File: rtl/sseg_pkg.sv
// Shared types and the hex-to-segment decode table for the seven-segment scan driver.
// Pure combinational helpers; no latency, no flow control.
package sseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
    seg7_t s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Scan timebase: slot prescaler, digit index and per-slot PWM counter.
// slot_tick/frame_end are combinational from the counters; free-running, no backpressure.
module sseg_scan_timer #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 62500,
  parameter int PWM_BITS    = 4,
  localparam int IDX_W      = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                slot_tick,
  output logic                frame_end,
  output logic [IDX_W-1:0]    idx,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0] presc;

  assign slot_tick = (presc == PRE_W'(REFRESH_DIV - 1));
  assign frame_end = slot_tick && (idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else if (slot_tick) begin
      // Restarting PWM with the slot gives every digit the same on-window phase.
      presc   <= '0;
      pwm_cnt <= '0;
      idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      presc   <= presc + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with double-buffered loads, LZ blanking, PWM and blink.
// an/seg registered one cycle after the digit index; load is a fire-and-forget strobe, never stalled.
module sseg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 62500,
  parameter int PWM_BITS    = 4,
  parameter int BLINK_LOG2  = 5,
  localparam int IDX_W      = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  import sseg_pkg::*;

  logic                  slot_tick;
  logic                  frame_end;
  logic [IDX_W-1:0]      idx;
  logic [PWM_BITS-1:0]   pwm_cnt;

  logic [4*DIGITS-1:0]   stage_hex, act_hex;
  logic [DIGITS-1:0]     stage_dp, act_dp;
  logic                  pending;
  logic [BLINK_LOG2-1:0] frm_cnt;
  logic                  blink_phase;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  pwm_on;
  logic                  lit;

  sseg_scan_timer #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .PWM_BITS    (PWM_BITS)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .slot_tick (slot_tick),
    .frame_end (frame_end),
    .idx       (idx),
    .pwm_cnt   (pwm_cnt)
  );

  assert property (@(posedge clk) disable iff (reset) frame_end |-> slot_tick);

  // Active only changes on the frame boundary, so a frame never mixes old and new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_hex <= '0;
      stage_dp  <= '0;
      act_hex   <= '0;
      act_dp    <= '0;
      pending   <= 1'b0;
    end else if (frame_end) begin
      pending <= 1'b0;
      if (load) begin
        stage_hex <= hex_in;
        stage_dp  <= dp_in;
        act_hex   <= hex_in;
        act_dp    <= dp_in;
      end else if (pending) begin
        act_hex <= stage_hex;
        act_dp  <= stage_dp;
      end
    end else if (load) begin
      stage_hex <= hex_in;
      stage_dp  <= dp_in;
      pending   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      frm_cnt <= frm_cnt + BLINK_LOG2'(1);
      if (&frm_cnt)
        blink_phase <= ~blink_phase;
    end
  end

  // Walk down from the top digit; blanking stops at the first non-zero nibble or lit dp.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (act_hex[4*k +: 4] == 4'h0) && !act_dp[k];
      lz_mask[k] = zero_above;
    end
  end

  assign cur_nib = act_hex[{idx, 2'b00} +: 4];
  assign cur_dp  = act_dp[idx];
  assign pwm_on  = (&brightness) || (pwm_cnt < brightness);
  assign lit     = pwm_on
                 && !(blank_lz && lz_mask[idx])
                 && !(blink_phase && blink_mask[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (lit) begin
        an  <= ~(DIGITS'(1) << idx);
        seg <= {~cur_dp, hex_to_seg7(cur_nib)};
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboarded bench for sseg_scan_ctrl: a cycle-indexed reference model predicts an/seg/frame_tick,
// a separate monitor pops and compares each cycle's prediction.
module tb_sseg_scan_ctrl;

  localparam int D     = 4;
  localparam int RD    = 32;
  localparam int PB    = 4;
  localparam int BL    = 1;
  localparam int FRAME = RD * D;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  typedef struct {
    int unsigned t;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        ft;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: cycles since reset release, last loaded data, data on display.
  int unsigned t;
  logic [15:0] m_latest_hex, m_act_hex;
  logic [3:0]  m_latest_dp, m_act_dp;
  logic [6:0]  seg_tbl[16];

  sseg_scan_ctrl #(
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .PWM_BITS    (PB),
    .BLINK_LOG2  (BL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset();
    t            = 0;
    m_latest_hex = '0;
    m_act_hex    = '0;
    m_latest_dp  = '0;
    m_act_dp     = '0;
  endtask

  // Called at a negedge with this cycle's inputs applied; predicts the output after the next posedge.
  task automatic step();
    exp_t e;
    int   slot, idx, frame, pwm;
    logic on, lz, bk;
    slot  = int'(t / RD);
    idx   = slot % D;
    frame = slot / D;
    pwm   = int'(t % RD) % (1 << PB);
    on    = (brightness == 4'hF) || (pwm < int'(brightness));
    lz    = blank_lz && (idx != 0) && ((m_act_hex >> (4 * idx)) == 16'h0)
            && ((m_act_dp >> idx) == 4'h0);
    bk    = (((frame >> BL) % 2) == 1) && blink_mask[idx];
    e.t   = t;
    e.ft  = ((t % FRAME) == FRAME - 1);
    if (on && !lz && !bk) begin
      e.an  = ~(4'b0001 << idx);
      e.seg = {~m_act_dp[idx], seg_tbl[m_act_hex[4*idx +: 4]]};
    end else begin
      e.an  = 4'hF;
      e.seg = 8'hFF;
    end
    exp_q.push_back(e);
    if (load) begin
      m_latest_hex = hex_in;
      m_latest_dp  = dp_in;
    end
    if (e.ft) begin
      m_act_hex = m_latest_hex;
      m_act_dp  = m_latest_dp;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++) step();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d);
    hex_in = h;
    dp_in  = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic count_lit(input string name, input int want);
    int cnt;
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (an != 4'hF) cnt++;
      step();
    end
    check(name, cnt, want);
  endtask

  // Monitor: one prediction per displayed cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (an !== e.an || seg !== e.seg || frame_tick !== e.ft) begin
          bad++;
          $display("FAIL scan t=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                   e.t, an, seg, frame_tick, e.an, e.seg, e.ft);
        end
      end
    end
  end

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset      = 1'b1;
    hex_in     = '0;
    dp_in      = '0;
    load       = 1'b0;
    blank_lz   = 1'b0;
    blink_mask = '0;
    brightness = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 8'hFF);
    check("reset_frame_tick", frame_tick, 1'b0);

    // Reset mid-scan with digit 2 lit, outputs must go dark without a clock edge.
    reset = 1'b0;
    run(200);
    check("pre_reset_an", an, 4'b1011);
    reset = 1'b1;
    #1;
    check("async_reset_an", an, 4'hF);
    check("async_reset_seg", seg, 8'hFF);
    check("async_reset_ft", frame_tick, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(1);
    check("first_anode", an, 4'b1110);
    check("first_seg", seg, 8'hC0);

    // Basic load and decode.
    do_load(16'h12AF, 4'b0010);
    run_to(0);
    run(FRAME);

    // Mid-frame loads wait for the boundary; later loads overwrite staging; boundary load goes straight in.
    run_to(40);
    do_load(16'h3333, 4'b0000);
    run_to(0);
    run(FRAME / 2);
    do_load(16'h5555, 4'hF);
    run(10);
    do_load(16'h6666, 4'b0000);
    run_to(FRAME - 1);
    do_load(16'h789A, 4'b1000);
    run(FRAME);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    run_to(0);
    run(FRAME);
    do_load(16'h0000, 4'b0000);
    run_to(0);
    run(FRAME);
    do_load(16'h0000, 4'b0100);
    run_to(0);
    run(FRAME);
    blank_lz = 1'b0;

    // PWM duty.
    do_load(16'h1234, 4'b0000);
    brightness = 4'd4;
    run(FRAME);
    count_lit("pwm4_lit_cycles", 32);
    brightness = 4'd0;
    run(4);
    count_lit("pwm0_lit_cycles", 0);
    brightness = 4'hF;
    run(4);
    count_lit("pwm15_lit_cycles", FRAME);

    // Blink on digit 0 across several phase changes.
    blink_mask = 4'b0001;
    run(6 * FRAME);
    blink_mask = 4'b0000;

    // Randomized traffic.
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0: hex_in = 16'($urandom) & 16'h000F;
          1: hex_in = 16'($urandom) & 16'h00FF;
          2: hex_in = 16'($urandom) & 16'h0FFF;
          default: hex_in = 16'($urandom);
        endcase
        dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        load  = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 299) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 299) == 0) blink_mask = 4'($urandom);
      step();
      load = 1'b0;
    end

    run(2);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
